// File: rtl/diff_serial_tx.sv
// Differential serial transmitter: framed LSB-first words (start, data, optional even
// parity, stop) on a registered line bit that drives an OBUFDS pad buffer.
module diff_serial_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter bit          PARITY_EN  = 1'b1,
  parameter              IOSTANDARD = "DEFAULT"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_p,
  output logic              tx_n
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            r_state, w_state_d;
  logic [DIV_W-1:0]  r_div, w_div_d;
  logic [BIT_W-1:0]  r_bit, w_bit_d;
  logic [DATA_W-1:0] r_shift, w_shift_d;
  logic              r_parity, w_parity_d;
  logic              r_line, w_line_d;
  logic              w_div_last;

  assign w_div_last = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_line   <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_div    <= w_div_d;
      r_bit    <= w_bit_d;
      r_shift  <= w_shift_d;
      r_parity <= w_parity_d;
      r_line   <= w_line_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_div_d    = r_div;
    w_bit_d    = r_bit;
    w_shift_d  = r_shift;
    w_parity_d = r_parity;

    if (r_state != StIdle) begin
      w_div_d = w_div_last ? '0 : r_div + DIV_W'(1);
    end

    unique case (r_state)
      StIdle: begin
        if (tx_valid) begin
          w_shift_d  = tx_data;
          w_parity_d = ^tx_data;
          w_bit_d    = '0;
          w_div_d    = '0;
          w_state_d  = StStart;
        end
      end
      StStart: begin
        if (w_div_last) w_state_d = StData;
      end
      StData: begin
        if (w_div_last) begin
          w_shift_d = r_shift >> 1;
          // Bit counter holds at its terminal count rather than wrapping.
          if (r_bit == BIT_LAST) begin
            w_state_d = PARITY_EN ? StParity : StStop;
          end else begin
            w_bit_d = r_bit + BIT_W'(1);
          end
        end
      end
      StParity: begin
        if (w_div_last) w_state_d = StStop;
      end
      StStop: begin
        if (w_div_last) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // The line is registered from the current state, so it trails the state by one cycle.
  always_comb begin
    w_line_d = 1'b1;
    unique case (r_state)
      StIdle:   w_line_d = 1'b1;
      StStart:  w_line_d = 1'b0;
      StData:   w_line_d = r_shift[0];
      StParity: w_line_d = r_parity;
      StStop:   w_line_d = 1'b1;
      default:  w_line_d = 1'b1;
    endcase
  end

  assign tx_ready = (r_state == StIdle);
  assign tx_busy  = (r_state != StIdle);

`ifdef DIFF_SERIAL_TX_XILINX
  OBUFDS #(
    .IOSTANDARD(IOSTANDARD)
  ) u_obufds (
    .I (r_line),
    .O (tx_p),
    .OB(tx_n)
  );
`else
  // Behavioural stand-in for the pad buffer when the vendor primitive is not available.
  logic w_unused_iostd;
  assign w_unused_iostd = (IOSTANDARD == "DEFAULT");
  assign tx_p = r_line;
  assign tx_n = ~r_line;
`endif

endmodule

// File: doc/diff_serial_tx.md
# diff_serial_tx

Differential serial transmitter: accepts parallel words over a valid/ready handshake and sends them as framed, LSB-first serial bits. Each frame carries a start bit, the data bits, an optional even-parity bit and a stop bit. The registered line drives an OBUFDS primitive, so the block is the board-level output counterpart of the IBUFDS-based receive path. It sits at the top-level pad boundary; tx_p/tx_n connect directly to top-level ports.

## Interface
- DATA_W, 8: payload width in bits; must be ≥ 1.
- CLK_DIV, 4: clock cycles per serial bit; must be ≥ 1.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data; 0 omits it.
- IOSTANDARD, "DEFAULT": passed unchanged to the OBUFDS IOSTANDARD parameter.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to send; sampled only on an accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- tx_busy  output  1  a frame is in progress.
- tx_p  output  1  differential output, positive leg (OBUFDS O).
- tx_n  output  1  differential output, negative leg (OBUFDS OB).

## Operation
- Internal registered line bit `line_q` drives OBUFDS I. Idle/mark level is line_q = 1, giving tx_p = 1 and tx_n = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - tx_ready = 1, tx_busy = 0, line_q = 1.
    - On tx_valid && tx_ready: latch tx_data into the shift register, compute even parity (XOR of all data bits), clear the bit counter, go to START.
  - START: line_q = 0 for CLK_DIV cycles, then go to DATA.
  - DATA:
    - line_q = shift_reg[0]; each bit is held for CLK_DIV cycles, then the register shifts right.
    - After DATA_W bits, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
  - PARITY: line_q = parity bit for CLK_DIV cycles, then go to STOP.
  - STOP: line_q = 1 for CLK_DIV cycles, then go to IDLE.
- tx_ready = 1 only in IDLE. tx_busy = 1 in every state except IDLE.
- Changes on tx_data or tx_valid after the accept are ignored until the block returns to IDLE.
- Counters:
  - Divider counter is $clog2(CLK_DIV) bits wide, with a minimum of 1 bit; it counts 0..CLK_DIV-1.
  - Bit counter is $clog2(DATA_W+1) bits wide.
  - No wrap beyond the terminal count.
- Reset:
  - Asynchronous assertion forces IDLE and line_q = 1, and clears both counters and the shift register.
  - Reset mid-frame aborts the frame immediately; the partial word is discarded and not resent.
  - Reset values: tx_ready = 1, tx_busy = 0, tx_p = 1, tx_n = 0.

## Timing
- Accept on edge k: line_q goes low (start bit) on edge k+1.
- Every bit lasts exactly CLK_DIV cycles, including when CLK_DIV = 1.
- Frame length F = (2 + DATA_W + PARITY_EN) × CLK_DIV cycles. tx_busy is high for exactly F cycles.
- After the stop bit, IDLE lasts at least 1 cycle, so the shortest frame-to-frame period is F + 1 cycles. tx_valid held high continuously yields frames spaced exactly F + 1 cycles apart.
- tx_p/tx_n follow line_q with only the OBUFDS delay; they are always complementary in simulation.

## Test plan
- Single frame, defaults (DATA_W=8, CLK_DIV=4, PARITY_EN=1), tx_data = 0xA5:
  - Required line sequence, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 0 (parity) | 1 (stop).
  - tx_busy high for 44 cycles; tx_ready returns high on cycle 45.
- Back-to-back 0x00 then 0xFF with tx_valid held high:
  - Second start bit begins exactly 45 cycles after the first.
  - Parity bit is 0 for 0x00 and 0 for 0xFF.
- Word 0x01 accepted, then tx_data changed to 0x80 while busy: transmitted data bits are still 1,0,0,0,0,0,0,0.
- Reset asserted during data bit 3 of 0x3C:
  - tx_p = 1, tx_n = 0 immediately; tx_busy = 0 and tx_ready = 1.
  - Next accepted word 0x55 is sent as a complete, correct frame.
- CLK_DIV=1, PARITY_EN=0, tx_data = 0xFF: line sequence 0,1,1,1,1,1,1,1,1,1, one cycle per bit; tx_busy high for 10 cycles.
- Idle check: no tx_valid for 100 cycles after reset → tx_p = 1, tx_n = 0, tx_busy = 0 and tx_ready = 1 throughout.
